// File: rtl/mem_access_unit.sv
// Memory access sequencer: turns LOAD / STORE / FILL / reserved requests into
// single-port RAM cycles and a one-cycle registered completion pulse.
module mem_access_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-1:0] req_count,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              ram_write_enable,
    output logic              ram_read,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STORE = 3'd2,
        S_FILL  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_rd_q, ram_rd_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_rd_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ram_we_q     <= ram_we_d;
            ram_rd_q     <= ram_rd_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    // Next-state logic; cnt_q holds the FILL writes still to issue after the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = ram_addr_q;
        wdata_d = ram_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_base + req_offset;
                    wdata_d = req_wdata;
                    case (req_op)
                        2'b00:   state_d = S_LOAD;
                        2'b01:   state_d = S_STORE;
                        2'b10: begin
                            if (req_count == '0) begin
                                state_d = S_RESP;
                            end else begin
                                state_d = S_FILL;
                                cnt_d   = req_count - ADDR_W'(1);
                            end
                        end
                        default: state_d = S_RESP;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD:  state_d = S_RESP;
            S_STORE: state_d = S_RESP;
            S_FILL: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d  = cnt_q - ADDR_W'(1);
                    addr_d = ram_addr_q + ADDR_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from state_d.
    always_comb begin
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        resp_err_d   = (state_q == S_IDLE) && req_valid && (req_op == 2'b11);
        ram_rd_d     = (state_d == S_LOAD);
        ram_we_d     = (state_d == S_STORE) || (state_d == S_FILL);
        if (ram_rd_d || ram_we_d) begin
            ram_addr_d = addr_d;
        end else begin
            ram_addr_d = '0;
        end
        if (ram_we_d) begin
            ram_wdata_d = wdata_d;
        end else begin
            ram_wdata_d = '0;
        end
        if (state_q == S_LOAD) begin
            resp_rdata_d = ram_rdata;
        end else begin
            resp_rdata_d = resp_rdata_q;
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_err         = resp_err_q;
    assign ram_write_enable = ram_we_q;
    assign ram_read         = ram_rd_q;
    assign ram_addr         = ram_addr_q;
    assign ram_wdata        = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomised bench for mem_access_unit with a behavioural RAM
// and an independent 256-word reference model.
module tb_mem_access_unit;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_base;
    logic [7:0]  req_offset;
    logic [15:0] req_wdata;
    logic [7:0]  req_count;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        ram_write_enable;
    logic        ram_read;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [15:0] ram [256];
    logic [15:0] mdl [256];
    logic        init_done;
    logic [15:0] last_rd;
    int          total;
    int          bad;

    mem_access_unit #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .req_count(req_count),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_write_enable(ram_write_enable), .ram_read(ram_read),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, synchronous write, preloaded with i*7.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'(i * 7);
        end else if (ram_write_enable) begin
            ram[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = ram[ram_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 32'(req_ready), 32'd1);
        check_val({tag, "_valid"}, 32'(resp_valid), 32'd0);
        check_val({tag, "_err"}, 32'(resp_err), 32'd0);
        check_val({tag, "_rdata"}, 32'(resp_rdata), 32'd0);
        check_val({tag, "_we"}, 32'(ram_write_enable), 32'd0);
        check_val({tag, "_rd"}, 32'(ram_read), 32'd0);
        check_val({tag, "_addr"}, 32'(ram_addr), 32'd0);
        check_val({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    endtask

    // Called at a negedge in an IDLE cycle; runs one request to completion and
    // returns at the negedge of the response cycle.
    task automatic run_req(input logic [1:0] op, input logic [7:0] base, input logic [7:0] off,
                           input logic [15:0] wd, input logic [7:0] cnt, input bit hold);
        logic [7:0] eff;
        logic [7:0] a;
        int         lat;
        bit         done;
        bit         exp_rd;
        bit         exp_we;
        eff = base + off;
        if (op == 2'b00 || op == 2'b01) lat = 2;
        else if (op == 2'b10) lat = int'(cnt) + 1;
        else lat = 1;
        check_val("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_base = base; req_offset = off;
        req_wdata = wd; req_count = cnt;
        @(posedge clk);
        #1;
        req_valid = hold;
        req_op = 2'($urandom); req_base = 8'($urandom); req_offset = 8'($urandom);
        req_wdata = 16'($urandom); req_count = 8'($urandom);
        done = 1'b0;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(negedge clk);
            exp_rd = (op == 2'b00) && (k == 1);
            exp_we = ((op == 2'b01) && (k == 1)) || ((op == 2'b10) && (k <= int'(cnt)));
            a = (op == 2'b10) ? 8'(eff + 8'(k - 1)) : eff;
            check_val("excl", 32'(ram_read & ram_write_enable), 32'd0);
            check_val("rd", 32'(ram_read), 32'(exp_rd));
            check_val("we", 32'(ram_write_enable), 32'(exp_we));
            check_val("addr", 32'(ram_addr), (exp_rd || exp_we) ? 32'(a) : 32'd0);
            check_val("wdata", 32'(ram_wdata), exp_we ? 32'(wd) : 32'd0);
            check_val("busy_ready", 32'(req_ready), 32'd0);
            if (exp_we) mdl[a] = wd;
            check_val("valid", 32'(resp_valid), 32'(k == lat));
            if (k == lat && op == 2'b00) last_rd = mdl[eff];
            check_val("rdata", 32'(resp_rdata), 32'(last_rd));
            if (resp_valid) begin
                check_val("err", 32'(resp_err), 32'(op == 2'b11));
                done = 1'b1;
            end
        end
        if (!done) check_val("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        total = 0; bad = 0; last_rd = 16'h0000; init_done = 1'b0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_base = 8'h00;
        req_offset = 8'h00; req_wdata = 16'h0000; req_count = 8'h00;
        for (int i = 0; i < 256; i++) mdl[i] = 16'(i * 7);
        @(posedge clk);
        #1 init_done = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        // first request goes in on the first edge after release
        run_req(2'b01, 8'h10, 8'h05, 16'hBEEF, 8'h00, 1'b0);
        @(negedge clk);
        run_req(2'b00, 8'h10, 8'h05, 16'h0000, 8'h00, 1'b0);
        check_val("load_beef", 32'(resp_rdata), 32'h0000BEEF);
        @(negedge clk);
        run_req(2'b10, 8'hFE, 8'h00, 16'h00AA, 8'h04, 1'b0);
        @(negedge clk);
        check_val("ram_wrap0", 32'(ram[8'h00]), 32'h000000AA);
        check_val("ram_ff", 32'(ram[8'hFF]), 32'h000000AA);
        check_val("ram_02", 32'(ram[8'h02]), 32'(16'd14));
        run_req(2'b00, 8'hF0, 8'h10, 16'h0000, 8'h00, 1'b0);
        @(negedge clk);
        run_req(2'b00, 8'h40, 8'h03, 16'h0000, 8'h00, 1'b0);
        @(negedge clk);
        run_req(2'b10, 8'h30, 8'h01, 16'h1234, 8'h00, 1'b0);
        @(negedge clk);
        run_req(2'b11, 8'h30, 8'h01, 16'h1234, 8'h05, 1'b0);
        @(negedge clk);
        run_req(2'b10, 8'h80, 8'h80, 16'h7777, 8'h01, 1'b0);
        @(negedge clk);

        // reset in the middle of a 10-word fill, after three writes
        req_valid = 1'b1; req_op = 2'b10; req_base = 8'h20; req_offset = 8'h00;
        req_wdata = 16'h5A5A; req_count = 8'd10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) mdl[8'h20 + i] = 16'h5A5A;
        #1 check_reset_outputs("abort");
        last_rd = 16'h0000;
        @(negedge clk);
        check_reset_outputs("abort_hold");
        for (int i = 0; i < 10; i++) check_val("fill_abort", 32'(ram[8'h20 + i]), 32'(mdl[8'h20 + i]));
        rst_n = 1'b1;
        run_req(2'b01, 8'h22, 8'h00, 16'hC0DE, 8'h00, 1'b0);

        // random back-to-back traffic with req_valid never dropped
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            run_req(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                    16'($urandom), 8'($urandom_range(0, 5)), 1'b1);
        end
        for (int i = 0; i < 256; i++) check_val("final_ram", 32'(ram[i]), 32'(mdl[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
